// File: rtl/logic_element_pkg.sv
// Shared definitions for the logic element: default LUT depth and the
// encoding of the mode bit held at the top of the configuration word.
package logic_element_pkg;

  localparam int unsigned LUT_SIZE_DEFAULT = 16;

  // Mode bit cfg[LUT_SIZE]: selects the LUT output directly or via the user register.
  typedef enum logic {
    MODE_COMB = 1'b0,
    MODE_REG  = 1'b1
  } le_mode_e;

endpackage

// File: rtl/logic_element_if.sv
// Serial configuration bus of one logic element.
//   en        global configuration enable
//   config_en shift enable
//   data_in   serial input, MSB first
//   data_out  serial output towards the next element's chain
// master: the side feeding the chain; slave: the chain itself.
interface logic_element_if;
  logic en;
  logic config_en;
  logic data_in;
  logic data_out;

  modport master (output en, output config_en, output data_in, input data_out);
  modport slave  (input en, input config_en, input data_in, output data_out);
endinterface

// File: rtl/logic_element_config_chain.sv
// Configuration shift register of one logic element.
//   clk, nrst : configuration clock and async active-low clear
//   cfg_bus   : serial configuration bus (slave side)
//   cfg       : parallel configuration word {mode, lut[LUT_SIZE-1:0]}
module le_config_chain
  import logic_element_pkg::*;
#(
  parameter int unsigned LUT_SIZE = LUT_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                nrst,
  logic_element_if.slave      cfg_bus,
  output logic [LUT_SIZE:0]   cfg
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cfg <= '0;
    end else if (cfg_bus.en && cfg_bus.config_en) begin
      cfg <= {cfg[LUT_SIZE-1:0], cfg_bus.data_in};
    end
  end

  // Taken straight from the register so neighbouring chains never see a
  // combinational path from config_data_in.
  assign cfg_bus.data_out = cfg[LUT_SIZE];

endmodule

// File: rtl/logic_element.sv
// Single FPGA logic element: LUT_SIZE-entry LUT with an optional output
// register, programmed through a daisy-chainable serial configuration chain.
//   clk, nrst        configuration clock / async active-low chain clear
//   en, config_en    configuration enables (both needed to shift)
//   config_data_in   serial configuration input, MSB (mode) first
//   config_data_out  serial configuration output (registered)
//   le_clk, le_nrst  user register clock / async active-low clear
//   le_en            user register load enable
//   select           LUT address
//   le_out           element output
module logic_element
  import logic_element_pkg::*;
#(
  parameter int unsigned LUT_SIZE  = LUT_SIZE_DEFAULT,
  parameter int unsigned SEL_WIDTH = $clog2(LUT_SIZE)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 config_en,
  input  logic                 config_data_in,
  output logic                 config_data_out,
  input  logic                 le_clk,
  input  logic                 le_nrst,
  input  logic                 le_en,
  input  logic [SEL_WIDTH-1:0] select,
  output logic                 le_out
);

  logic_element_if cfg_bus ();

  assign cfg_bus.en        = en;
  assign cfg_bus.config_en = config_en;
  assign cfg_bus.data_in   = config_data_in;
  assign config_data_out   = cfg_bus.data_out;

  logic [LUT_SIZE:0]   cfg;
  logic [LUT_SIZE-1:0] lut;
  le_mode_e            mode;
  logic                lut_out;
  logic                q;

  le_config_chain #(.LUT_SIZE(LUT_SIZE)) u_chain (
    .clk     (clk),
    .nrst    (nrst),
    .cfg_bus (cfg_bus),
    .cfg     (cfg)
  );

  assign lut     = cfg[LUT_SIZE-1:0];
  assign mode    = le_mode_e'(cfg[LUT_SIZE]);
  assign lut_out = lut[select];

  // User register runs in every mode so a mode switch exposes the current q.
  always_ff @(posedge le_clk or negedge le_nrst) begin
    if (!le_nrst) begin
      q <= 1'b0;
    end else if (le_en) begin
      q <= lut_out;
    end
  end

  always_comb begin
    le_out = lut_out;
    if (mode == MODE_REG) le_out = q;
  end

endmodule

// File: tb/tb_logic_element.sv
module tb_logic_element;

  logic       clk = 1'b0;
  logic       nrst;
  logic       le_clk = 1'b0;
  logic       le_nrst;
  logic       le_en;
  logic [3:0] select;
  logic       le_out;

  logic_element_if bus ();

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  logic_element #(.LUT_SIZE(16)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .en              (bus.en),
    .config_en       (bus.config_en),
    .config_data_in  (bus.data_in),
    .config_data_out (bus.data_out),
    .le_clk          (le_clk),
    .le_nrst         (le_nrst),
    .le_en           (le_en),
    .select          (select),
    .le_out          (le_out)
  );

  // Model: history of bits accepted by the chain. The bit shifted in k shifts
  // ago sits at cfg[k]; anything older than 17 shifts has left the element.
  bit   hist[$];
  logic mq;

  function automatic logic cfg_bit(int k);
    if (k < hist.size()) return hist[hist.size()-1-k];
    return 1'b0;
  endfunction

  function automatic logic model_out();
    if (cfg_bit(16)) return mq;
    return cfg_bit(int'(select));
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) hist.delete();
    else if (bus.en && bus.config_en) begin
      hist.push_back(bus.data_in);
      if (hist.size() > 17) void'(hist.pop_front());
    end
  end

  always @(posedge le_clk or negedge le_nrst) begin
    if (!le_nrst) mq = 1'b0;
    else if (le_en) mq = cfg_bit(int'(select));
  end

  task automatic check(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the active clk edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_le_out", le_out, model_out());
      check("model_cfg_out", bus.data_out, cfg_bit(16));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic le_pulse();
    #1 le_clk = 1'b1;
    #1 le_clk = 1'b0;
    #1;
  endtask

  task automatic shift_bit(logic b);
    bus.en = 1'b1;
    bus.config_en = 1'b1;
    bus.data_in = b;
    tick();
    bus.config_en = 1'b0;
  endtask

  task automatic load(logic mode, logic [15:0] lut);
    shift_bit(mode);
    for (int i = 15; i >= 0; i--) shift_bit(lut[i]);
  endtask

  logic [15:0] parity;
  logic [16:0] pat_a;
  logic [16:0] pat_b;

  initial begin
    parity = 16'h6996;
    pat_a  = 17'h1_A5C3;
    pat_b  = 17'h0_3C5A;
    nrst = 1'b0; le_nrst = 1'b0; le_en = 1'b0; select = '0;
    bus.en = 1'b0; bus.config_en = 1'b0; bus.data_in = 1'b0;
    tick(); tick();
    check("reset_le_out", le_out, 1'b0);
    check("reset_cfg_out", bus.data_out, 1'b0);
    nrst = 1'b1; le_nrst = 1'b1;
    chk_en = 1'b1;

    // Mode 0, parity LUT: zero-latency lookup.
    load(1'b0, parity);
    for (int s = 0; s < 16; s++) begin
      select = 4'(s);
      #1 check("comb_parity", le_out, parity[s]);
      tick();
    end
    select = 4'd3; #1 check("comb_sel3", le_out, 1'b0);
    select = 4'd7; #1 check("comb_sel7", le_out, 1'b1);

    // Mode 1, parity LUT: output follows the select captured at le_clk.
    load(1'b1, parity);
    le_en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      select = 4'(s);
      le_pulse();
      select = 4'(s + 7);
      #1 check("reg_parity", le_out, parity[s]);
      tick();
    end

    // Hold with le_en low.
    load(1'b1, 16'h0001);
    select = 4'd0; le_en = 1'b1;
    le_pulse();
    check("reg_load1", le_out, 1'b1);
    le_en = 1'b0; select = 4'd1;
    repeat (3) le_pulse();
    check("reg_hold", le_out, 1'b1);
    tick();

    // Asynchronous user reset, no clock edge.
    le_nrst = 1'b0;
    #1 check("le_nrst_async", le_out, 1'b0);
    le_nrst = 1'b1;
    tick();

    // Replay: after 17 shifts the chain emits the first bit, MSB first.
    for (int i = 16; i >= 0; i--) shift_bit(pat_a[i]);
    for (int i = 16; i >= 0; i--) begin
      check("replay", bus.data_out, pat_a[i]);
      shift_bit(pat_b[i]);
    end

    // Freeze with either enable low.
    bus.data_in = 1'b1;
    bus.en = 1'b0; bus.config_en = 1'b1;
    repeat (3) tick();
    bus.en = 1'b1; bus.config_en = 1'b0;
    repeat (3) tick();
    check("freeze_cfg_out", bus.data_out, 1'b0);
    for (int s = 0; s < 16; s++) begin
      select = 4'(s);
      #1 check("freeze_lut", le_out, pat_b[s]);
      tick();
    end

    // Chain reset mid-load.
    for (int i = 0; i < 8; i++) shift_bit(1'b1);
    nrst = 1'b0;
    #1 check("nrst_cfg_out", bus.data_out, 1'b0);
    tick();
    nrst = 1'b1;
    for (int s = 0; s < 16; s++) begin
      select = 4'(s);
      #1 check("nrst_lut_zero", le_out, 1'b0);
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
